// File: rtl/led7seg_scan_if.sv
// Value-in / segment-and-anode-out bundle for the 4-digit scanned display driver.
interface led7seg_scan_if;
  logic [3:0] I;    // value to display, 0..15
  logic [7:0] LED;  // segments: [0]=a .. [6]=g, [7]=dp
  logic [3:0] SA;   // digit enables, bit k = digit k

  // Value source: drives I, observes the pins
  modport master (
    output I,
    input  LED,
    input  SA
  );

  // Display driver
  modport slave (
    input  I,
    output LED,
    output SA
  );
endinterface

// File: rtl/led7seg_scan.sv
// Multiplexed 4-digit common-anode 7-segment driver.
// Digits 1:0 show the value in decimal (tens blanked when zero), digit 2 is blank,
// digit 3 shows the value as one hex character with its decimal point lit.
module led7seg_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  led7seg_scan_if.slave bus
);

  localparam int unsigned CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [7:0] LedOff = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0] SaOff  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  // Active-high g..a pattern for one hex character
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [3:0]      i_q, i_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      led_q, led_d;
  logic [3:0]      sa_q, sa_d;

  logic       cnt_wrap;
  logic       tens_nz;
  logic [3:0] ones;
  logic [7:0] glyph;
  logic [3:0] sa_onehot;

  // Prescaler, digit index and output decode from the current (pre-edge) index,
  // so SA and LED always change on the same edge and each digit dwells SCAN_DIV cycles.
  always_comb begin
    i_d      = bus.I;
    cnt_wrap = (cnt_q == CntMax);
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;

    // 0..15 only needs one conditional subtract for the decimal split
    tens_nz = (i_q >= 4'd10);
    ones    = tens_nz ? i_q - 4'd10 : i_q;

    glyph = 8'h00;
    unique case (idx_q)
      2'd0: glyph = {1'b0, hex_glyph(ones)};
      2'd1: glyph = tens_nz ? {1'b0, hex_glyph(4'd1)} : 8'h00;
      2'd2: glyph = 8'h00;
      2'd3: glyph = {1'b1, hex_glyph(i_q)};
      default: glyph = 8'h00;
    endcase

    led_d     = SEG_ACTIVE_LOW ? ~glyph : glyph;
    sa_onehot = 4'b0001 << idx_q;
    sa_d      = AN_ACTIVE_LOW ? ~sa_onehot : sa_onehot;
  end

  // State and registered pin drivers; reset blanks the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q   <= 4'd0;
      cnt_q <= '0;
      idx_q <= 2'd0;
      led_q <= LedOff;
      sa_q  <= SaOff;
    end else begin
      i_q   <= i_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      led_q <= led_d;
      sa_q  <= sa_d;
    end
  end

  assign bus.LED = led_q;
  assign bus.SA  = sa_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Bench for led7seg_scan: two instances (SCAN_DIV=1 and 3) fed the same value and
// compared against an arithmetic model of what each digit should show on each edge.
module tb_led7seg_scan;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] ival;

  always #5 clk = ~clk;

  led7seg_scan_if if1 ();
  led7seg_scan_if if3 ();

  assign if1.I = ival;
  assign if3.I = ival;

  led7seg_scan #(.SCAN_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  led7seg_scan #(.SCAN_DIV(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;             // edges since reset release
  logic [3:0] hist [0:8191];    // I as seen on each edge; hist[0] = reset value of capture

  // Segment table, active-high, g..a
  function automatic logic [7:0] seg_of(input int v);
    case (v)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  10: return 8'h77; 11: return 8'h7C;
      12: return 8'h39; 13: return 8'h5E; 14: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  function automatic int digit_at(input int div, input int t);
    return ((t - 1) / div) % 4;
  endfunction

  // LED on edge t: value captured one edge earlier, shown on the digit scheduled for t
  function automatic logic [7:0] exp_led(input int div, input int t);
    int v, d;
    logic [7:0] g;
    v = int'(hist[t-1]);
    d = digit_at(div, t);
    case (d)
      0: g = seg_of(v % 10);
      1: g = (v >= 10) ? seg_of(v / 10) : 8'h00;
      2: g = 8'h00;
      default: g = seg_of(v) | 8'h80;
    endcase
    return ~g;
  endfunction

  function automatic logic [3:0] exp_sa(input int div, input int t);
    logic [3:0] one;
    one = 4'b0001 << digit_at(div, t);
    return ~one;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    hist[cyc] = ival;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;
    hist[0] = 4'd0;
  endtask

  task automatic test_reset();
    ival  = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (if1.LED !== 8'hFF) begin failures++; $display("FAIL reset_led1 got=%h exp=ff", if1.LED); end
    if (if1.SA !== 4'hF) begin failures++; $display("FAIL reset_sa1 got=%h exp=f", if1.SA); end
    if (if3.LED !== 8'hFF) begin failures++; $display("FAIL reset_led3 got=%h exp=ff", if3.LED); end
    if (if3.SA !== 4'hF) begin failures++; $display("FAIL reset_sa3 got=%h exp=f", if3.SA); end
    release_reset();
    step();
    checks += 4;
    if (if1.SA !== 4'b1110) begin failures++; $display("FAIL first_sa1 got=%b exp=1110", if1.SA); end
    if (if3.SA !== 4'b1110) begin failures++; $display("FAIL first_sa3 got=%b exp=1110", if3.SA); end
    if (if1.LED !== 8'hC0) begin failures++; $display("FAIL first_led1 got=%h exp=c0", if1.LED); end
    if (if3.LED !== 8'hC0) begin failures++; $display("FAIL first_led3 got=%h exp=c0", if3.LED); end
  endtask

  task automatic test_sweep();
    logic [8:0] spec;
    for (int v = 15; v >= 0; v--) begin
      ival = 4'(v);
      repeat (8) begin
        step();
        checks += 4;
        if (if1.LED !== exp_led(1, cyc)) begin
          failures++; $display("FAIL sweep_led1 t=%0d got=%h exp=%h", cyc, if1.LED, exp_led(1, cyc));
        end
        if (if1.SA !== exp_sa(1, cyc)) begin
          failures++; $display("FAIL sweep_sa1 t=%0d got=%b exp=%b", cyc, if1.SA, exp_sa(1, cyc));
        end
        if (if3.LED !== exp_led(3, cyc)) begin
          failures++; $display("FAIL sweep_led3 t=%0d got=%h exp=%h", cyc, if3.LED, exp_led(3, cyc));
        end
        if (if3.SA !== exp_sa(3, cyc)) begin
          failures++; $display("FAIL sweep_sa3 t=%0d got=%b exp=%b", cyc, if3.SA, exp_sa(3, cyc));
        end
        // Spot values written out literally for 15, 9 and 0 once the value has settled
        spec = 9'h000;
        if (int'(hist[cyc-1]) == v) begin
          case ({v[7:0], 6'(digit_at(1, cyc))})
            {8'd15, 6'd0}: spec = {1'b1, 8'b10010010};
            {8'd15, 6'd1}: spec = {1'b1, 8'b11111001};
            {8'd15, 6'd3}: spec = {1'b1, 8'b00001110};
            {8'd9, 6'd0}:  spec = {1'b1, 8'b10010000};
            {8'd9, 6'd1}:  spec = {1'b1, 8'hFF};
            {8'd9, 6'd3}:  spec = {1'b1, 8'b00010000};
            {8'd0, 6'd0}:  spec = {1'b1, 8'b11000000};
            {8'd0, 6'd1}:  spec = {1'b1, 8'hFF};
            default:       spec = 9'h000;
          endcase
        end
        if (spec[8]) begin
          checks++;
          if (if1.LED !== spec[7:0]) begin
            failures++; $display("FAIL sweep_spot v=%0d got=%b exp=%b", v, if1.LED, spec[7:0]);
          end
        end
        if (if1.SA === 4'b1011) begin
          checks++;
          if (if1.LED !== 8'hFF) begin
            failures++; $display("FAIL digit2_blank v=%0d got=%h exp=ff", v, if1.LED);
          end
        end
      end
    end
  endtask

  task automatic test_scan_timing();
    for (int k = 0; k < 48; k++) begin
      if (k % 7 == 0) ival = 4'($urandom_range(0, 15));
      step();
      checks += 4;
      if (if3.SA !== exp_sa(3, cyc)) begin
        failures++; $display("FAIL scan_sa3 t=%0d got=%b exp=%b", cyc, if3.SA, exp_sa(3, cyc));
      end
      if (if3.LED !== exp_led(3, cyc)) begin
        failures++; $display("FAIL scan_led3 t=%0d got=%h exp=%h", cyc, if3.LED, exp_led(3, cyc));
      end
      if ($countones(~if3.SA) != 1) begin
        failures++; $display("FAIL onehot_sa3 t=%0d got=%b exp=one_low", cyc, if3.SA);
      end
      if ($countones(~if1.SA) != 1) begin
        failures++; $display("FAIL onehot_sa1 t=%0d got=%b exp=one_low", cyc, if1.SA);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      ival = 4'($urandom_range(0, 15));
      step();
      checks += 4;
      if (if1.LED !== exp_led(1, cyc)) begin
        failures++; $display("FAIL rand_led1 t=%0d got=%h exp=%h", cyc, if1.LED, exp_led(1, cyc));
      end
      if (if1.SA !== exp_sa(1, cyc)) begin
        failures++; $display("FAIL rand_sa1 t=%0d got=%b exp=%b", cyc, if1.SA, exp_sa(1, cyc));
      end
      if (if3.LED !== exp_led(3, cyc)) begin
        failures++; $display("FAIL rand_led3 t=%0d got=%h exp=%h", cyc, if3.LED, exp_led(3, cyc));
      end
      if (if3.SA !== exp_sa(3, cyc)) begin
        failures++; $display("FAIL rand_sa3 t=%0d got=%b exp=%b", cyc, if3.SA, exp_sa(3, cyc));
      end
    end
  endtask

  task automatic test_latency();
    bit found = 1'b0;
    ival = 4'd3;
    step();
    step();
    for (int k = 0; k < 16 && !found; k++) begin
      step();
      if ((cyc - 1) % 3 == 0 && digit_at(3, cyc) == 0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL latency_sync got=no_digit0 exp=digit0_within_16");
    end else begin
      ival = 4'd8;
      step();
      checks += 2;
      if (if3.LED !== 8'b10110000) begin
        failures++; $display("FAIL latency_old got=%b exp=10110000", if3.LED);
      end
      if (if3.SA !== 4'b1110) begin
        failures++; $display("FAIL latency_sa_a got=%b exp=1110", if3.SA);
      end
      step();
      checks += 2;
      if (if3.LED !== 8'b10000000) begin
        failures++; $display("FAIL latency_new got=%b exp=10000000", if3.LED);
      end
      if (if3.SA !== 4'b1110) begin
        failures++; $display("FAIL latency_sa_b got=%b exp=1110", if3.SA);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      ival = 4'($urandom_range(0, 15));
      step();
      if (digit_at(3, cyc) == 3) found = 1'b1;
    end
    checks++;
    if (!found || if3.SA !== 4'b0111) begin
      failures++; $display("FAIL areset_sync got=%b exp=0111", if3.SA);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (if3.LED !== 8'hFF) begin failures++; $display("FAIL areset_led3 got=%h exp=ff", if3.LED); end
    if (if3.SA !== 4'hF) begin failures++; $display("FAIL areset_sa3 got=%h exp=f", if3.SA); end
    if (if1.LED !== 8'hFF) begin failures++; $display("FAIL areset_led1 got=%h exp=ff", if1.LED); end
    if (if1.SA !== 4'hF) begin failures++; $display("FAIL areset_sa1 got=%h exp=f", if1.SA); end
    @(posedge clk);
    release_reset();
    for (int k = 0; k < 20; k++) begin
      step();
      checks += 2;
      if (if3.SA !== exp_sa(3, cyc)) begin
        failures++; $display("FAIL restart_sa3 t=%0d got=%b exp=%b", cyc, if3.SA, exp_sa(3, cyc));
      end
      if (if3.LED !== exp_led(3, cyc)) begin
        failures++; $display("FAIL restart_led3 t=%0d got=%h exp=%h", cyc, if3.LED, exp_led(3, cyc));
      end
      ival = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_scan_timing();
    test_random();
    test_latency();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
